// File: rtl/seq_pkg.sv
// seq_pkg: shared encodings for the microprogram sequencer and its helpers.
package seq_pkg;
    localparam logic [1:0] NXT_INC = 2'b00, NXT_IB = 2'b01, NXT_SB = 2'b10, NXT_JMP = 2'b11;
    localparam logic [1:0] COND_ALWAYS = 2'b00, COND_Z = 2'b01, COND_C = 2'b10, COND_NZ = 2'b11;
    typedef enum logic [1:0] {S_RUN = 2'b00, S_WAIT_IR = 2'b01, S_HALT = 2'b10} state_t;
    localparam logic [4:0] DEF_RESET_UPC = 5'b00000;
endpackage

// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: instruction-register handshake between decoder (master) and sequencer (slave).
interface micro_sequencer_if #(parameter int UW = 5);
    logic [UW-1:0] ib;
    logic [UW-1:0] sb;
    logic          ir_valid;
    logic          ir_ack;
    modport master (output ib, sb, ir_valid, input ir_ack);
    modport slave (input ib, sb, ir_valid, output ir_ack);
endinterface

// File: rtl/micro_cond_eval.sv
// micro_cond_eval: combinational branch-condition evaluation from ALU flags.
module micro_cond_eval import seq_pkg::*; (
    input  logic [1:0] ctl_cond,
    input  logic       zero_flag,
    input  logic       carry_flag,
    output logic       cond_true
);
    always_comb cond_true = (ctl_cond == COND_ALWAYS) | (ctl_cond == COND_Z & zero_flag) |
                            (ctl_cond == COND_C & carry_flag) | (ctl_cond == COND_NZ & ~zero_flag);
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: micro-PC sequencing with IB/SB dispatch, conditional branches, IR handshake, stall and halt.
module micro_sequencer import seq_pkg::*; #(
    parameter int            UW        = 5,
    parameter logic [UW-1:0] RESET_UPC = UW'(DEF_RESET_UPC),
    parameter int            CW        = 8
) (
    input  logic              clk,
    input  logic              reset,
    micro_sequencer_if.slave  ir,
    input  logic [1:0]        ctl_next,
    input  logic [UW-1:0]     ctl_addr,
    input  logic [1:0]        ctl_cond,
    input  logic              ctl_end,
    input  logic              ctl_halt,
    input  logic              stall,
    input  logic              zero_flag,
    input  logic              carry_flag,
    input  logic              resume,
    output logic [UW-1:0]     upc,
    output logic [UW-1:0]     sb_reg,
    output logic [CW-1:0]     step_cnt,
    output logic              dispatch,
    output logic              halted
);
    state_t        state_q, state_d;
    logic [UW-1:0] upc_q, upc_d, sb_q, sb_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_sat;
    logic          dispatch_q, dispatch_d, cond_true, go_ib;

    micro_cond_eval u_cond (
        .ctl_cond   (ctl_cond),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .cond_true  (cond_true)
    );

    assign cnt_sat = &cnt_q ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        upc_d      = upc_q;
        sb_d       = sb_q;
        cnt_d      = cnt_q;
        dispatch_d = 1'b0;
        go_ib      = 1'b0;
        if (!stall) begin
            case (state_q)
                S_RUN:
                    if (ctl_halt) state_d = S_HALT;
                    else if (ctl_end) begin
                        upc_d = RESET_UPC;
                        cnt_d = '0;
                    end else if (cond_true && ctl_next == NXT_IB) begin
                        go_ib   = ir.ir_valid;
                        state_d = ir.ir_valid ? S_RUN : S_WAIT_IR;
                    end else begin
                        upc_d = (!cond_true || ctl_next == NXT_INC) ? upc_q + 1'b1 :
                                (ctl_next == NXT_SB) ? sb_q : ctl_addr;
                        cnt_d = cnt_sat;
                    end
                S_WAIT_IR: begin
                    go_ib   = ir.ir_valid;
                    state_d = ir.ir_valid ? S_RUN : S_WAIT_IR;
                end
                S_HALT:
                    if (resume) begin
                        upc_d   = RESET_UPC;
                        state_d = S_RUN;
                    end
                default: state_d = S_RUN;
            endcase
            if (go_ib) begin
                upc_d      = ir.ib;
                sb_d       = ir.sb;
                cnt_d      = '0;
                dispatch_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_RUN;
            upc_q      <= RESET_UPC;
            sb_q       <= '0;
            cnt_q      <= '0;
            dispatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            upc_q      <= upc_d;
            sb_q       <= sb_d;
            cnt_q      <= cnt_d;
            dispatch_q <= dispatch_d;
        end
    end

    // dispatch and ir_ack are the same registered pulse seen by two consumers
    assign ir.ir_ack = dispatch_q;
    assign dispatch  = dispatch_q;
    assign upc       = upc_q;
    assign sb_reg    = sb_q;
    assign step_cnt  = cnt_q;
    assign halted    = state_q == S_HALT;
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed vectors with hand-computed expectations for micro_sequencer.
module tb_micro_sequencer;
    logic       clk, reset;
    logic [1:0] ctl_next, ctl_cond;
    logic [4:0] ctl_addr, upc, sb_reg;
    logic [7:0] step_cnt;
    logic       ctl_end, ctl_halt, stall, zero_flag, carry_flag, resume, dispatch, halted;
    int         n_cmp = 0, n_err = 0;

    micro_sequencer_if #(.UW(5)) ir_bus ();

    micro_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .ir         (ir_bus),
        .ctl_next   (ctl_next),
        .ctl_addr   (ctl_addr),
        .ctl_cond   (ctl_cond),
        .ctl_end    (ctl_end),
        .ctl_halt   (ctl_halt),
        .stall      (stall),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .resume     (resume),
        .upc        (upc),
        .sb_reg     (sb_reg),
        .step_cnt   (step_cnt),
        .dispatch   (dispatch),
        .halted     (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; ctl_next = 2'b00; ctl_cond = 2'b00; ctl_addr = '0;
        ctl_end = 0; ctl_halt = 0; stall = 0; zero_flag = 0; carry_flag = 0; resume = 0;
        ir_bus.ib = '0; ir_bus.sb = '0; ir_bus.ir_valid = 0;
        #12;
        check("rst_upc", 32'(upc), 0);
        check("rst_disp", 32'(dispatch), 0);
        check("rst_ack", 32'(ir_bus.ir_ack), 0);
        check("rst_halt", 32'(halted), 0);
        reset = 1'b0;
        // dispatch then goto SB
        ctl_next = 2'b01; ir_bus.ir_valid = 1; ir_bus.ib = 5'd20; ir_bus.sb = 5'd10;
        tick();
        check("disp_upc", 32'(upc), 20);
        check("disp_sb", 32'(sb_reg), 10);
        check("disp_pulse", 32'(dispatch), 1);
        check("disp_ack", 32'(ir_bus.ir_ack), 1);
        check("disp_cnt", 32'(step_cnt), 0);
        ctl_next = 2'b10; ir_bus.ir_valid = 0;
        tick();
        check("gosb_upc", 32'(upc), 10);
        check("gosb_pulse", 32'(dispatch), 0);
        check("gosb_ack", 32'(ir_bus.ir_ack), 0);
        check("gosb_cnt", 32'(step_cnt), 1);
        ctl_next = 2'b11; ctl_addr = 5'd7;
        tick();
        check("jmp7_upc", 32'(upc), 7);
        // asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        check("arst_upc", 32'(upc), 0);
        check("arst_sb", 32'(sb_reg), 0);
        check("arst_cnt", 32'(step_cnt), 0);
        check("arst_halt", 32'(halted), 0);
        #1 reset = 1'b0;
        // handshake: wait for IR; ctl_* ignored while waiting
        ctl_next = 2'b01;
        tick();
        check("wait1_upc", 32'(upc), 0);
        ctl_next = 2'b00;
        tick();
        check("wait2_upc", 32'(upc), 0);
        tick();
        check("wait3_upc", 32'(upc), 0);
        check("wait3_ack", 32'(ir_bus.ir_ack), 0);
        ir_bus.ir_valid = 1; ir_bus.ib = 5'd5; ir_bus.sb = 5'd3;
        tick();
        check("hs_upc", 32'(upc), 5);
        check("hs_ack", 32'(ir_bus.ir_ack), 1);
        check("hs_sb", 32'(sb_reg), 3);
        ir_bus.ir_valid = 0;
        tick();
        check("hs_ack_end", 32'(ir_bus.ir_ack), 0);
        check("hs_run_upc", 32'(upc), 6);
        check("hs_run_cnt", 32'(step_cnt), 1);
        // conditional branches
        ctl_cond = 2'b01; ctl_next = 2'b11; ctl_addr = 5'd9; zero_flag = 0;
        tick();
        check("bz_nt_upc", 32'(upc), 7);
        zero_flag = 1;
        tick();
        check("bz_t_upc", 32'(upc), 9);
        ctl_cond = 2'b11; ctl_addr = 5'd20;
        tick();
        check("bnz_nt_upc", 32'(upc), 10);
        ctl_cond = 2'b10; carry_flag = 1; ctl_addr = 5'd31;
        tick();
        check("bc_t_upc", 32'(upc), 31);
        check("bc_t_cnt", 32'(step_cnt), 5);
        // wrap then stall with a pending dispatch
        ctl_cond = 2'b00; ctl_next = 2'b00; zero_flag = 0; carry_flag = 0;
        tick();
        check("wrap_upc", 32'(upc), 0);
        check("wrap_cnt", 32'(step_cnt), 6);
        stall = 1; ctl_next = 2'b01; ir_bus.ir_valid = 1; ir_bus.ib = 5'd17; ir_bus.sb = 5'd2;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_upc", 32'(upc), 0);
            check("stall_cnt", 32'(step_cnt), 6);
            check("stall_disp", 32'(dispatch), 0);
            check("stall_ack", 32'(ir_bus.ir_ack), 0);
            check("stall_sb", 32'(sb_reg), 3);
        end
        stall = 0; ctl_next = 2'b00; ir_bus.ir_valid = 0;
        tick();
        check("unstall_upc", 32'(upc), 1);
        check("unstall_cnt", 32'(step_cnt), 7);
        // halt / resume
        ctl_halt = 1;
        tick();
        check("halt_flag", 32'(halted), 1);
        check("halt_upc", 32'(upc), 1);
        ctl_halt = 0; ctl_next = 2'b11; ctl_addr = 5'd14;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("halted_upc", 32'(upc), 1);
            check("halted_flag", 32'(halted), 1);
        end
        resume = 1;
        tick();
        check("resume_upc", 32'(upc), 0);
        check("resume_flag", 32'(halted), 0);
        resume = 0;
        // end of instruction
        tick();
        check("jmp14_upc", 32'(upc), 14);
        check("jmp14_cnt", 32'(step_cnt), 8);
        ctl_end = 1;
        tick();
        check("end_upc", 32'(upc), 0);
        check("end_cnt", 32'(step_cnt), 0);
        // saturation of step counter
        ctl_end = 0; ctl_next = 2'b00;
        repeat (260) tick();
        check("sat_cnt", 32'(step_cnt), 255);
        check("sat_upc", 32'(upc), 4);
        // trap target dispatches normally
        ctl_next = 2'b01; ir_bus.ir_valid = 1; ir_bus.ib = 5'd31; ir_bus.sb = 5'd6;
        tick();
        check("trap_upc", 32'(upc), 31);
        check("trap_cnt", 32'(step_cnt), 0);
        check("trap_disp", 32'(dispatch), 1);
        ir_bus.ir_valid = 0; ctl_next = 2'b00;
        tick();
        check("trap_disp_end", 32'(dispatch), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogram sequencer for the CISC core. It is the consumer of the instruction decoder's IB (dispatch target) and SB (secondary target) codes.
- Holds the micro-program counter (upc) that addresses the control-store ROM, and selects the next micro-address from increment, IB dispatch, latched SB, or an explicit jump.
- Handles conditional branching, instruction-register handshake, stall and halt.

Parameters:
- UW, 5, micro-address width; matches the IB/SB code width.
- RESET_UPC, 5'b00000, micro-address of the fetch routine; used on reset, end-of-instruction and resume.
- CW, 8, width of the step counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ib  in  UW  dispatch target from the instruction decoder.
- sb  in  UW  secondary target from the instruction decoder.
- ir_valid  in  1  IR holds a freshly fetched instruction, so ib/sb are meaningful.
- ir_ack  out  1  one-cycle pulse: ib/sb consumed, IR may be reused.
- ctl_next  in  2  next-address select from the control word: 00 inc, 01 dispatch IB, 10 goto SB, 11 goto ctl_addr.
- ctl_addr  in  UW  explicit jump address from the control word.
- ctl_cond  in  2  branch condition: 00 always, 01 zero, 10 carry, 11 not-zero.
- ctl_end  in  1  end of instruction; return to fetch.
- ctl_halt  in  1  halt micro-op.
- stall  in  1  datapath/memory busy; freeze the sequencer.
- zero_flag  in  1  ALU zero flag.
- carry_flag  in  1  ALU carry flag.
- resume  in  1  leave HALT.
- upc  out  UW  current micro-address, registered.
- sb_reg  out  UW  SB latched at the last dispatch.
- step_cnt  out  CW  micro-steps since the last dispatch; saturating.
- dispatch  out  1  one-cycle pulse on the cycle after a dispatch takes effect.
- halted  out  1  high in the HALT state.

Behaviour:
- States: RUN, WAIT_IR, HALT. Encoding is registered, 2 bits.
- Reset (asynchronous) sets: state=RUN, upc=RESET_UPC, sb_reg=0, step_cnt=0, dispatch=0, ir_ack=0, halted=0. Assertion mid-instruction abandons it immediately.
- The control store reads combinationally from upc, so ctl_* refer to the current upc in the same cycle. All decisions below are evaluated at the rising edge.
- Priority, highest first: reset > stall > state logic.
- stall=1: every register holds, including state. dispatch and ir_ack are 0 that cycle.
- RUN, in priority order:
  - ctl_halt=1: go to HALT; upc holds.
  - Else ctl_end=1: upc=RESET_UPC; step_cnt=0.
  - Else evaluate the condition: cond_true = always | zero_flag | carry_flag | ~zero_flag, according to ctl_cond. If cond_true=0, upc=upc+1 regardless of ctl_next.
  - If cond_true=1, act on ctl_next:
    - 00: upc=upc+1.
    - 01 with ir_valid=1: upc=ib, sb_reg=sb, step_cnt=0, dispatch=1 and ir_ack=1 on the next cycle.
    - 01 with ir_valid=0: go to WAIT_IR; upc holds.
    - 10: upc=sb_reg.
    - 11: upc=ctl_addr.
- WAIT_IR: upc holds and step_cnt holds. When ir_valid=1, perform the dispatch above and return to RUN. ctl_* are ignored in this state.
- HALT: halted=1; upc holds. resume=1 sets upc=RESET_UPC, state=RUN, halted=0 on the next cycle.
- upc+1 wraps modulo 2^UW, so 31 becomes 0 with no flag.
- step_cnt increments on every RUN advance that is not a dispatch or end. It saturates at 2^CW-1 and is cleared by dispatch or end.
- dispatch and ir_ack are registered pulses, high for exactly one cycle per dispatch. They never assert during stall.
- ib=5'b11111 is dispatched like any other target; the trap routine lives at that address.

Decomposition:
- Package seq_pkg holds:
  - NXT_INC/NXT_IB/NXT_SB/NXT_JMP constants.
  - COND_ALWAYS/COND_Z/COND_C/COND_NZ constants.
  - State encoding constants.
  - RESET_UPC default.
- One sub-module, micro_cond_eval: combinational cond_true from ctl_cond, zero_flag and carry_flag. It is reused by the branch unit.

Test Plan:
- Reset mid-run with upc=7: assert reset -> upc=0, sb_reg=0, step_cnt=0, halted=0 immediately, without waiting for a clock edge.
- Dispatch: ctl_next=01, ir_valid=1, ib=5'b10100, sb=5'b01010 -> next cycle upc=20, sb_reg=10, dispatch=1 and ir_ack=1 for one cycle. Then ctl_next=10 -> upc=10.
- Handshake: ctl_next=01 with ir_valid=0 for 3 cycles -> upc holds and state is WAIT_IR. Raise ir_valid with ib=5'b00101 -> upc=5 on the next cycle, one ir_ack pulse.
- Conditional branch: ctl_cond=01, ctl_next=11, ctl_addr=9, zero_flag=0 -> upc=upc+1. Same with zero_flag=1 -> upc=9.
- Wrap and stall: upc=31, ctl_next=00 -> upc=0. Then stall=1 for 2 cycles -> upc, step_cnt and state frozen, with no dispatch pulse.
- Halt and end: ctl_halt=1 -> halted=1, upc frozen for 5 cycles. resume=1 -> upc=0, halted=0. Separately, ctl_end=1 at upc=14 -> upc=0, step_cnt=0.
